// File: rtl/bt_uart_tx.sv
// bt_uart_tx: Avalon-MM slave UART transmitter (8N1) with TX FIFO and programmable baud divisor.
// Defining BT_UART_TX_IRQ_EN adds the irq output and the CTRL[1] irq_en bit.
module bt_uart_tx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        txd
`ifdef BT_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV0    = DIV_W'((CLK_HZ + BAUD / 2) / BAUD);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             en_q, en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_lat_q, div_lat_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
    logic             txd_q, txd_d;
    logic [31:0]      rdata_q, rdata_d;
`ifdef BT_UART_TX_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
`endif

    logic wr, rd, push, push_ok, pop, full, empty, busy, bit_end;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign wr      = chipselect & write;
    assign rd      = chipselect & read;
    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign busy    = (state_q != IDLE);
    assign bit_end = (baud_q == '0);
    assign push    = wr & (address == 2'd0);
    assign push_ok = push & (~full | pop);

    // Next-state logic for the serializer FSM, FIFO bookkeeping and register file.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        div_lat_d = div_lat_q;
        pop       = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        en_d      = en_q;
        div_d     = div_q;
        txd_d     = 1'b1;
        rdata_d   = '0;
`ifdef BT_UART_TX_IRQ_EN
        irq_en_d  = irq_en_q;
        irq_d     = irq_en_q & ((empty & ~busy) | ovf_q);
`endif

        case (state_q)
            IDLE: begin
                if (en_q && !empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    div_lat_d = div_q;
                    baud_d    = div_q - DIV_W'(1);
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = div_lat_q - DIV_W'(1);
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = div_lat_q - DIV_W'(1);
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (en_q && !empty) begin
                        pop       = 1'b1;
                        shift_d   = fifo_mem[rd_ptr_q];
                        div_lat_d = div_q;
                        baud_d    = div_q - DIV_W'(1);
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // txd follows the current state, so the line lags the FSM by one cycle.
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (wr && address == 2'd1 && writedata[3]) ovf_d = 1'b0;
        if (push && full && !pop)                  ovf_d = 1'b1;

        if (wr && address == 2'd2) begin
            div_d = (writedata[15:0] < DIV_MIN) ? DIV_MIN : writedata[15:0];
        end
        if (wr && address == 2'd3) begin
            en_d = writedata[0];
`ifdef BT_UART_TX_IRQ_EN
            irq_en_d = writedata[1];
`endif
        end

        if (rd) begin
            case (address)
                2'd1: begin
                    rdata_d[0]    = full;
                    rdata_d[1]    = empty;
                    rdata_d[2]    = busy;
                    rdata_d[3]    = ovf_q;
                    rdata_d[12:8] = 5'(count_q);
                end
                2'd2: rdata_d[15:0] = div_q;
                2'd3: begin
                    rdata_d[0] = en_q;
`ifdef BT_UART_TX_IRQ_EN
                    rdata_d[1] = irq_en_q;
`endif
                end
                default: rdata_d = '0;
            endcase
        end
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            div_lat_q <= DIV0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b1;
            div_q     <= DIV0;
            txd_q     <= 1'b1;
            rdata_q   <= '0;
`ifdef BT_UART_TX_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            div_lat_q <= div_lat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            div_q     <= div_d;
            txd_q     <= txd_d;
            rdata_q   <= rdata_d;
`ifdef BT_UART_TX_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= writedata[7:0];
    end

    assign readdata = rdata_q;
    assign txd      = txd_q;
`ifdef BT_UART_TX_IRQ_EN
    assign irq      = irq_q;
`endif

endmodule
